pipeline_seq_ctrl: RTL and testbench
====================================

PIPELINE_SEQ_CTRL -- requirements
Module: pipeline_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of cycle counter.
REQ-002 SHALL have ports:
  i_clk  in  1  single clock; all state updates on rising edge.
  i_reset  in  1  synchronous, active-high reset.
  i_run  in  1  level; request continuous execution.
  i_step  in  1  single-cycle pulse; request one pipeline advance.
  i_load_use  in  1  load-use hazard detected in ID.
  i_branch_taken  in  1  branch/jump resolved taken in ID.
  i_wb_halt  in  1  halt marker present at MEM/WB latch output.
  o_pc_en  out  1  PC register enable.
  o_if_id_en  out  1  IF/ID latch enable.
  o_if_id_flush  out  1  IF/ID latch flush.
  o_id_ex_en  out  1  ID/EX latch enable.
  o_id_ex_flush  out  1  ID/EX latch flush (bubble insert).
  o_ex_mem_en  out  1  EX/MEM latch enable.
  o_mem_wb_en  out  1  MEM/WB latch enable.
  o_halted  out  1  program halted; pipeline frozen.
  o_cycle_cnt  out  CNT_WIDTH  count of pipeline advance cycles.

Function
REQ-003 SHALL implement FSM states IDLE, RUN, STEP, HALTED; internal "adv" = 1 in RUN or STEP, else 0.
REQ-004 IDLE: i_run=1 -> RUN; else i_step=1 -> STEP; else stay; i_run wins if both asserted.
REQ-005 RUN: stays while i_run=1; i_run=0 -> IDLE next cycle (current cycle still advances).
REQ-006 STEP: lasts exactly one cycle, then -> IDLE regardless of i_step/i_run.
REQ-007 In RUN or STEP with i_wb_halt=1: adv forced 0 that cycle, next state HALTED.
REQ-008 HALTED: sticky; ignores i_run, i_step and all hazard inputs until reset.
REQ-009 Outputs SHALL be combinational from state and inputs, zero latency:
  o_pc_en = o_if_id_en = adv & ~i_load_use;
  o_id_ex_en = o_ex_mem_en = o_mem_wb_en = adv;
  o_id_ex_flush = adv & i_load_use;
  o_if_id_flush = adv & i_branch_taken & ~i_load_use.
REQ-010 Load-use and branch in same cycle: stall wins, flush suppressed; branch re-evaluated next advance cycle.
REQ-011 All enables and flushes SHALL be 0 in IDLE and HALTED regardless of inputs.
REQ-012 o_halted SHALL be 1 exactly when state is HALTED (registered, rises cycle after halt detection).
REQ-013 o_cycle_cnt SHALL increment by 1 on every clock with adv=1 (stall cycles included), saturate at all-ones, never wrap.

Reset
REQ-014 i_reset=1 at a clock edge SHALL force state IDLE, o_cycle_cnt=0, o_halted=0, from any state incl. mid-RUN, STEP or HALTED.
REQ-015 While i_reset=1, all enable and flush outputs SHALL be 0; i_reset dominates all other inputs.

Configuration
REQ-016 Macro PIPE_SEQ_CYCLE_CNT_EN defined: counter per REQ-013 built in.
REQ-017 Macro undefined: no counter registers; o_cycle_cnt tied to 0; all other behaviour unchanged.

Verification
REQ-018 Reset, pulse i_step once -> exactly one cycle with all enables=1; back to IDLE; o_cycle_cnt=1.
REQ-019 i_run=1 for 10 cycles, no hazards -> enables=1 for 10 cycles; o_cycle_cnt=10; i_run=0 -> enables 0 next cycle.
REQ-020 RUN with i_load_use=1 and i_branch_taken=1 same cycle -> o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_if_id_flush=0, o_ex_mem_en=1.
REQ-021 RUN, i_wb_halt=1 -> all enables 0 that cycle; o_halted=1 next cycle; i_run/i_step for 5 cycles -> no change; i_reset -> o_halted=0, o_cycle_cnt=0.
REQ-022 CNT_WIDTH=4 with macro defined, RUN 20 cycles -> o_cycle_cnt holds 15; macro undefined -> o_cycle_cnt=0 throughout.

Source files
------------

// File: rtl/pipeline_seq_ctrl_if.sv
// Pipeline sequencer control bundle: run/step/hazard requests in, latch controls out.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface pipeline_seq_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 i_run;
    logic                 i_step;
    logic                 i_load_use;
    logic                 i_branch_taken;
    logic                 i_wb_halt;
    logic                 o_pc_en;
    logic                 o_if_id_en;
    logic                 o_if_id_flush;
    logic                 o_id_ex_en;
    logic                 o_id_ex_flush;
    logic                 o_ex_mem_en;
    logic                 o_mem_wb_en;
    logic                 o_halted;
    logic [CNT_WIDTH-1:0] o_cycle_cnt;

    modport master (
        output i_run, i_step, i_load_use, i_branch_taken, i_wb_halt,
        input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
               o_ex_mem_en, o_mem_wb_en, o_halted, o_cycle_cnt
    );

    modport slave (
        input  i_run, i_step, i_load_use, i_branch_taken, i_wb_halt,
        output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
               o_ex_mem_en, o_mem_wb_en, o_halted, o_cycle_cnt
    );
endinterface

// File: rtl/pipeline_seq_ctrl.sv
// Pipeline sequencer: run/single-step/halt control of the five pipeline latches,
// with load-use stall and taken-branch flush gating.
// Optional advance-cycle counter built in when PIPE_SEQ_CYCLE_CNT_EN is defined;
// otherwise o_cycle_cnt is tied to zero.
module pipeline_seq_ctrl #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input logic                i_clk,
    input logic                i_reset,
    pipeline_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2,
        StHalted = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   active;
    logic   adv;

    // State register; reset returns to idle from any state, including halted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and advance qualification.
    always_comb begin
        state_d = state_q;
        active  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_run) begin
                    state_d = StRun;
                end else if (bus.i_step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                active = 1'b1;
                if (bus.i_wb_halt) begin
                    state_d = StHalted;
                end else if (!bus.i_run) begin
                    state_d = StIdle;
                end
            end
            StStep: begin
                active  = 1'b1;
                state_d = bus.i_wb_halt ? StHalted : StIdle;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A halt reaching write-back freezes the pipe in the same cycle; reset dominates.
        adv = active & ~bus.i_wb_halt & ~i_reset;
    end

    // Latch controls: a load-use stall holds PC and IF/ID and bubbles ID/EX,
    // and also suppresses the branch flush so the branch is re-resolved next advance.
    always_comb begin
        bus.o_pc_en       = adv & ~bus.i_load_use;
        bus.o_if_id_en    = adv & ~bus.i_load_use;
        bus.o_if_id_flush = adv & bus.i_branch_taken & ~bus.i_load_use;
        bus.o_id_ex_en    = adv;
        bus.o_id_ex_flush = adv & bus.i_load_use;
        bus.o_ex_mem_en   = adv;
        bus.o_mem_wb_en   = adv;
        bus.o_halted      = (state_q == StHalted);
    end

`ifdef PIPE_SEQ_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating count of advance cycles (stalls included).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (adv && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.o_cycle_cnt = cnt_q;
`else
    assign bus.o_cycle_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Self-checking bench for pipeline_seq_ctrl (CNT_WIDTH = 4 to reach saturation quickly).
module tb_pipeline_seq_ctrl;

    localparam int unsigned W = 4;
`ifdef PIPE_SEQ_CYCLE_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    localparam int MIdle = 0, MRun = 1, MStep = 2, MHalt = 3;

    typedef struct {
        logic [7:0] ctl;  // {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb, halted}
        logic [3:0] cnt;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset;

    pipeline_seq_ctrl_if #(.CNT_WIDTH(W)) bus ();

    pipeline_seq_ctrl #(.CNT_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   m_st;
    int   m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, push model expectation, compare at negedge, advance model.
    task automatic cyc(input logic rst, input logic run, input logic step, input logic lu,
                       input logic br, input logic halt, input string tag);
        exp_t e;
        exp_t g;
        bit   adv;
        i_reset            = rst;
        bus.i_run          = run;
        bus.i_step         = step;
        bus.i_load_use     = lu;
        bus.i_branch_taken = br;
        bus.i_wb_halt      = halt;
        adv   = ((m_st == MRun) || (m_st == MStep)) && !halt && !rst;
        e.ctl = {adv && !lu, adv && !lu, adv && br && !lu, adv, adv && lu, adv, adv,
                 m_st == MHalt};
        e.cnt = 4'(m_cnt);
        sb.push_back(e);
        @(negedge i_clk);
        g = sb.pop_front();
        check_eq({tag, ".ctl"},
                 {24'd0, bus.o_pc_en, bus.o_if_id_en, bus.o_if_id_flush, bus.o_id_ex_en,
                  bus.o_id_ex_flush, bus.o_ex_mem_en, bus.o_mem_wb_en, bus.o_halted},
                 {24'd0, g.ctl});
        check_eq({tag, ".cnt"}, {28'd0, bus.o_cycle_cnt}, {28'd0, g.cnt});
        @(posedge i_clk);
        if (rst) begin
            m_st  = MIdle;
            m_cnt = 0;
        end else begin
            if (adv && CntEn && (m_cnt < 15)) m_cnt++;
            case (m_st)
                MIdle:   m_st = run ? MRun : (step ? MStep : MIdle);
                MRun:    m_st = halt ? MHalt : (run ? MRun : MIdle);
                MStep:   m_st = halt ? MHalt : MIdle;
                default: m_st = MHalt;
            endcase
        end
        #1;
    endtask

    initial begin
        i_reset            = 1'b1;
        bus.i_run          = 1'b0;
        bus.i_step         = 1'b0;
        bus.i_load_use     = 1'b0;
        bus.i_branch_taken = 1'b0;
        bus.i_wb_halt      = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        m_st  = MIdle;
        m_cnt = 0;

        // Reset dominates every other input.
        cyc(1, 1, 1, 1, 1, 1, "rst_dom");
        cyc(0, 0, 0, 1, 1, 0, "idle");
        check_eq("reset_halted", {31'd0, bus.o_halted}, 32'd0);

        // Single step: one advance then idle.
        cyc(0, 0, 1, 0, 0, 0, "step_req");
        cyc(0, 0, 0, 0, 0, 0, "step_adv");
        cyc(0, 0, 0, 0, 0, 0, "step_done");
        check_eq("step_cnt", {28'd0, bus.o_cycle_cnt}, CntEn ? 32'd1 : 32'd0);

        // Ten advancing cycles, then idle.
        cyc(1, 0, 0, 0, 0, 0, "rst2");
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, "run10");
        cyc(0, 0, 0, 0, 0, 0, "run_last");
        cyc(0, 0, 0, 0, 0, 0, "run_off");
        check_eq("run_cnt", {28'd0, bus.o_cycle_cnt}, CntEn ? 32'd10 : 32'd0);

        // Hazards in RUN: stall beats branch flush.
        cyc(0, 1, 1, 0, 0, 0, "run_and_step");
        cyc(0, 1, 0, 1, 1, 0, "lu_br");
        cyc(0, 1, 0, 0, 1, 0, "br_only");
        cyc(0, 1, 0, 1, 0, 0, "lu_only");
        cyc(0, 0, 0, 0, 0, 0, "run_drop");

        // STEP lasts one cycle even with i_run held.
        cyc(0, 0, 1, 0, 0, 0, "step2_req");
        cyc(0, 1, 0, 0, 1, 0, "step2_adv");
        cyc(0, 1, 0, 0, 0, 0, "step2_idle");
        cyc(0, 1, 0, 0, 0, 0, "step2_run");

        // Halt in RUN, then sticky.
        cyc(0, 1, 0, 1, 1, 1, "halt_det");
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 1, 0, "halted_sticky");
        check_eq("halted_hi", {31'd0, bus.o_halted}, 32'd1);
        cyc(1, 1, 1, 0, 0, 0, "halt_rst");
        cyc(0, 0, 0, 0, 0, 0, "post_halt");
        check_eq("halt_clr", {31'd0, bus.o_halted}, 32'd0);
        check_eq("halt_cnt_clr", {28'd0, bus.o_cycle_cnt}, 32'd0);

        // Halt during STEP.
        cyc(0, 0, 1, 0, 0, 0, "step3_req");
        cyc(0, 0, 0, 0, 0, 1, "step3_halt");
        cyc(0, 0, 0, 0, 0, 0, "step3_halted");

        // Reset mid-RUN.
        cyc(1, 0, 0, 0, 0, 0, "rst3");
        cyc(0, 1, 0, 0, 0, 0, "run_a");
        cyc(0, 1, 0, 0, 0, 0, "run_b");
        cyc(1, 1, 0, 0, 0, 0, "rst_mid_run");
        cyc(0, 0, 0, 0, 0, 0, "after_rst");

        // Saturation.
        for (int i = 0; i < 21; i++) cyc(0, 1, 0, 0, 0, 0, "sat_run");
        cyc(0, 0, 0, 0, 0, 0, "sat_stop");
        check_eq("sat_cnt", {28'd0, bus.o_cycle_cnt}, CntEn ? 32'd15 : 32'd0);

        // Random mix.
        cyc(1, 0, 0, 0, 0, 0, "rst4");
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(39) == 0), $urandom_range(1) == 1, $urandom_range(3) == 0,
                $urandom_range(9) < 3, $urandom_range(9) < 3, $urandom_range(14) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
